// File: rtl/branch_condition_unit.sv
// rtl/branch_condition_unit.sv - MIPS-style branch decode, condition evaluation and delay-slot redirect unit
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_condition_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              stall,
    input  logic              flush,
    output logic              res_valid,
    output logic              is_branch,
    output logic              cond_true,
    output logic              link_en,
    output logic [4:0]        link_reg,
    output logic [31:0]       link_addr,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic              ds_err,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_REGIMM  = 6'd1;
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_BLEZ    = 6'd6;
    localparam logic [5:0] OP_BGTZ    = 6'd7;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    typedef enum logic {
        NORMAL     = 1'b0,
        DELAY_SLOT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        pend_taken_q, pend_taken_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        res_valid_q, res_valid_d;
    logic        is_branch_q, is_branch_d;
    logic        cond_true_q, cond_true_d;
    logic        link_en_q, link_en_d;
    logic [4:0]  link_reg_q, link_reg_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        ds_err_q, ds_err_d;

    logic [5:0]  opcode;
    logic [4:0]  rt_field;
    logic [5:0]  funct;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] rs_addr;
    logic        rs_neg;
    logic        rs_zero;
    logic        dec_branch;
    logic        dec_cond;
    logic        dec_link;
    logic [4:0]  dec_link_reg;
    logic [31:0] dec_target;
    logic        accept;
    logic        accept_nb;
    logic        accept_ds;

    assign opcode     = instruction[31:26];
    assign rt_field   = instruction[20:16];
    assign funct      = instruction[5:0];
    assign pc_plus4   = pc + 32'd4;
    assign br_target  = pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign jmp_target = {pc_plus4[31:28], instruction[25:0], 2'b00};
    assign rs_neg     = rs_val[DATA_W-1];
    assign rs_zero    = (rs_val == '0);

    // Register-indirect targets are a 32-bit address regardless of operand width.
    generate
        if (DATA_W >= 32) begin : g_rs_trunc
            assign rs_addr = rs_val[31:0];
        end else begin : g_rs_zext
            assign rs_addr = {{(32-DATA_W){1'b0}}, rs_val};
        end
    endgenerate

    always_comb begin
        dec_branch   = 1'b0;
        dec_cond     = 1'b0;
        dec_link     = 1'b0;
        dec_link_reg = 5'd31;
        dec_target   = br_target;
        case (opcode)
            OP_BEQ: begin
                dec_branch = 1'b1;
                dec_cond   = (rs_val == rt_val);
            end
            OP_BNE: begin
                dec_branch = 1'b1;
                dec_cond   = (rs_val != rt_val);
            end
            OP_BLEZ: begin
                dec_branch = 1'b1;
                dec_cond   = rs_neg | rs_zero;
            end
            OP_BGTZ: begin
                dec_branch = 1'b1;
                dec_cond   = ~rs_neg & ~rs_zero;
            end
            OP_REGIMM: begin
                case (rt_field)
                    RT_BLTZ: begin
                        dec_branch = 1'b1;
                        dec_cond   = rs_neg;
                    end
                    RT_BGEZ: begin
                        dec_branch = 1'b1;
                        dec_cond   = ~rs_neg;
                    end
                    RT_BLTZAL: begin
                        dec_branch = 1'b1;
                        dec_cond   = rs_neg;
                        dec_link   = 1'b1;
                    end
                    RT_BGEZAL: begin
                        dec_branch = 1'b1;
                        dec_cond   = ~rs_neg;
                        dec_link   = 1'b1;
                    end
                    default: dec_branch = 1'b0;
                endcase
            end
            OP_J: begin
                dec_branch = 1'b1;
                dec_cond   = 1'b1;
                dec_target = jmp_target;
            end
            OP_JAL: begin
                dec_branch = 1'b1;
                dec_cond   = 1'b1;
                dec_link   = 1'b1;
                dec_target = jmp_target;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR) begin
                    dec_branch = 1'b1;
                    dec_cond   = 1'b1;
                    dec_target = rs_addr;
                end else if (funct == FN_JALR) begin
                    dec_branch   = 1'b1;
                    dec_cond     = 1'b1;
                    dec_link     = 1'b1;
                    dec_link_reg = instruction[15:11];
                    dec_target   = rs_addr;
                end
            end
            default: dec_branch = 1'b0;
        endcase
    end

    assign accept    = in_valid & ~stall & ~flush;
    assign accept_nb = accept & (state_q == NORMAL);
    assign accept_ds = accept & (state_q == DELAY_SLOT);

    always_comb begin
        state_d       = state_q;
        pend_taken_d  = pend_taken_q;
        pend_target_d = pend_target_q;
        res_valid_d   = res_valid_q;
        is_branch_d   = is_branch_q;
        cond_true_d   = cond_true_q;
        link_en_d     = link_en_q;
        link_reg_d    = link_reg_q;
        link_addr_d   = link_addr_q;
        redirect_d    = redirect_q;
        redirect_pc_d = redirect_pc_q;
        ds_err_d      = ds_err_q;
        if (flush) begin
            state_d       = NORMAL;
            pend_taken_d  = 1'b0;
            pend_target_d = 32'd0;
            res_valid_d   = 1'b0;
            is_branch_d   = 1'b0;
            cond_true_d   = 1'b0;
            link_en_d     = 1'b0;
            redirect_d    = 1'b0;
            ds_err_d      = 1'b0;
        end else if (!stall) begin
            res_valid_d = accept;
            is_branch_d = 1'b0;
            cond_true_d = 1'b0;
            link_en_d   = 1'b0;
            redirect_d  = 1'b0;
            ds_err_d    = 1'b0;
            // The delay-slot instruction resolves the pending branch; a branch
            // here is demoted to a plain instruction and flagged.
            if (accept_ds) begin
                ds_err_d      = dec_branch;
                redirect_d    = pend_taken_q;
                if (pend_taken_q) begin
                    redirect_pc_d = pend_target_q;
                end
                state_d       = NORMAL;
                pend_taken_d  = 1'b0;
                pend_target_d = 32'd0;
            end else if (accept_nb) begin
                is_branch_d = dec_branch;
                cond_true_d = dec_branch & dec_cond;
                link_en_d   = dec_link;
                if (dec_link) begin
                    link_reg_d  = dec_link_reg;
                    link_addr_d = pc + 32'd8;
                end
                if (dec_branch) begin
                    state_d       = DELAY_SLOT;
                    pend_taken_d  = dec_cond;
                    pend_target_d = dec_target;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= NORMAL;
            pend_taken_q  <= 1'b0;
            pend_target_q <= 32'd0;
            res_valid_q   <= 1'b0;
            is_branch_q   <= 1'b0;
            cond_true_q   <= 1'b0;
            link_en_q     <= 1'b0;
            link_reg_q    <= 5'd0;
            link_addr_q   <= 32'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            ds_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_taken_q  <= pend_taken_d;
            pend_target_q <= pend_target_d;
            res_valid_q   <= res_valid_d;
            is_branch_q   <= is_branch_d;
            cond_true_q   <= cond_true_d;
            link_en_q     <= link_en_d;
            link_reg_q    <= link_reg_d;
            link_addr_q   <= link_addr_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            ds_err_q      <= ds_err_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign is_branch   = is_branch_q;
    assign cond_true   = cond_true_q;
    assign link_en     = link_en_q;
    assign link_reg    = link_reg_q;
    assign link_addr   = link_addr_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign ds_err      = ds_err_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             count_branch;
    logic             count_taken;

    assign count_branch = accept_nb & dec_branch;
    assign count_taken  = accept_ds & pend_taken_q;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (count_branch && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (count_taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;
`else
    assign branch_cnt = '0;
    assign taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_condition_unit.sv
// tb/tb_branch_condition_unit.sv - randomized self-checking bench for branch_condition_unit
module tb_branch_condition_unit;

    localparam int DATA_W = 32;
`ifdef BRANCH_STATS_EN
    localparam int CNT_W = 2;
    localparam bit STATS = 1'b1;
`else
    localparam int CNT_W = 16;
    localparam bit STATS = 1'b0;
`endif
    localparam int CMAX = (1 << CNT_W) - 1;

    localparam int K_NONE = 0, K_BEQ = 1, K_BNE = 2, K_BLEZ = 3, K_BGTZ = 4, K_BLTZ = 5,
                   K_BGEZ = 6, K_BLTZAL = 7, K_BGEZAL = 8, K_J = 9, K_JAL = 10, K_JR = 11, K_JALR = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [31:0]       instruction = 32'd0;
    logic [31:0]       pc = 32'd0;
    logic [DATA_W-1:0] rs_val = '0;
    logic [DATA_W-1:0] rt_val = '0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              res_valid, is_branch, cond_true, link_en, redirect, ds_err;
    logic [4:0]        link_reg;
    logic [31:0]       link_addr, redirect_pc;
    logic [CNT_W-1:0]  branch_cnt, taken_cnt;

    branch_condition_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction), .pc(pc),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .flush(flush),
        .res_valid(res_valid), .is_branch(is_branch), .cond_true(cond_true), .link_en(link_en),
        .link_reg(link_reg), .link_addr(link_addr), .redirect(redirect), .redirect_pc(redirect_pc),
        .ds_err(ds_err), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected outputs and the pending control transfer.
    bit          m_pending, m_ptaken;
    logic [31:0] m_ptarget;
    bit          e_rv, e_br, e_ct, e_le, e_rd, e_ds;
    logic [4:0]  e_lr;
    logic [31:0] e_la, e_rpc;
    int          m_bcnt, m_tcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int kind_of(input logic [31:0] ins);
        int k = K_NONE;
        case (ins[31:26])
            6'd0: if (ins[5:0] == 6'h08) k = K_JR; else if (ins[5:0] == 6'h09) k = K_JALR;
            6'd1: case (ins[20:16])
                      5'd0: k = K_BLTZ;
                      5'd1: k = K_BGEZ;
                      5'd16: k = K_BLTZAL;
                      5'd17: k = K_BGEZAL;
                      default: k = K_NONE;
                  endcase
            6'd2: k = K_J;
            6'd3: k = K_JAL;
            6'd4: k = K_BEQ;
            6'd5: k = K_BNE;
            6'd6: k = K_BLEZ;
            6'd7: k = K_BGTZ;
            default: k = K_NONE;
        endcase
        return k;
    endfunction

    function automatic bit taken_of(input int k, input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b);
        case (k)
            K_BEQ: return a == b;
            K_BNE: return a != b;
            K_BLEZ: return a <= 0;
            K_BGTZ: return a > 0;
            K_BLTZ, K_BLTZAL: return a < 0;
            K_BGEZ, K_BGEZAL: return a >= 0;
            K_NONE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] target_of(input int k, input logic [31:0] ins,
                                              input logic [31:0] p, input logic [DATA_W-1:0] a);
        logic [31:0] p4 = p + 32'd4;
        int          off = 4 * int'($signed(ins[15:0]));
        if (k == K_J || k == K_JAL) return {p4[31:28], ins[25:0], 2'b00};
        if (k == K_JR || k == K_JALR) return 32'(a);
        return p4 + 32'(off);
    endfunction

    task automatic model_update();
        int k = kind_of(instruction);
        bit br = (k != K_NONE);
        if (reset) begin
            {m_pending, m_ptaken, e_rv, e_br, e_ct, e_le, e_rd, e_ds} = '0;
            m_ptarget = 0; e_lr = 0; e_la = 0; e_rpc = 0; m_bcnt = 0; m_tcnt = 0;
        end else if (flush) begin
            {m_pending, m_ptaken, e_rv, e_br, e_ct, e_le, e_rd, e_ds} = '0;
        end else if (!stall) begin
            {e_rv, e_br, e_ct, e_le, e_rd, e_ds} = '0;
            if (in_valid) begin
                e_rv = 1'b1;
                if (m_pending) begin
                    e_ds = br;
                    if (m_ptaken) begin
                        e_rd = 1'b1; e_rpc = m_ptarget;
                        if (STATS && m_tcnt < CMAX) m_tcnt++;
                    end
                    m_pending = 1'b0;
                end else if (br) begin
                    e_br = 1'b1;
                    e_ct = taken_of(k, rs_val, rt_val);
                    if (k == K_JAL || k == K_JALR || k == K_BLTZAL || k == K_BGEZAL) begin
                        e_le = 1'b1;
                        e_lr = (k == K_JALR) ? instruction[15:11] : 5'd31;
                        e_la = pc + 32'd8;
                    end
                    m_pending = 1'b1; m_ptaken = e_ct;
                    m_ptarget = target_of(k, instruction, pc, rs_val);
                    if (STATS && m_bcnt < CMAX) m_bcnt++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("res_valid", res_valid, e_rv);
        check("is_branch", is_branch, e_br);
        check("cond_true", cond_true, e_ct);
        check("link_en", link_en, e_le);
        check("link_reg", link_reg, e_lr);
        check("link_addr", link_addr, e_la);
        check("redirect", redirect, e_rd);
        check("redirect_pc", redirect_pc, e_rpc);
        check("ds_err", ds_err, e_ds);
        check("branch_cnt", branch_cnt, m_bcnt);
        check("taken_cnt", taken_cnt, m_tcnt);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; instruction = ins; pc = p; rs_val = a; rt_val = b;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] enc_i(input int op, input int rt, input int imm);
        return {6'(op), 5'd3, 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] rand_instr();
        int sel = $urandom_range(0, 13);
        logic [31:0] r = $urandom;
        case (sel)
            0, 1, 2, 3: return enc_i(sel + 4, $urandom_range(0, 31), $urandom);
            4: return enc_i(1, 0, $urandom);
            5: return enc_i(1, 1, $urandom);
            6: return enc_i(1, 16, $urandom);
            7: return enc_i(1, 17, $urandom);
            8: return {6'd2, r[25:0]};
            9: return {6'd3, r[25:0]};
            10: return {6'd0, r[25:6], 6'h08};
            11: return {6'd0, r[25:6], 6'h09};
            default: return r;
        endcase
    endfunction

    initial begin
        logic [31:0] nop = 32'h0000_0000;
        logic [31:0] r;
        reset = 1'b1;
        step();
        step();
        check("rst_res_valid", res_valid, 0);
        check("rst_redirect", redirect, 0);
        check("rst_link_addr", link_addr, 0);
        reset = 1'b0;

        // BEQ taken, target pc+4+16
        issue(enc_i(4, 3, 4), 32'h100, 5, 5);
        check("beq_cond", cond_true, 1);
        issue(nop, 32'h104, 0, 0);
        check("beq_redirect", redirect, 1);
        check("beq_target", redirect_pc, 32'h114);
        step();
        check("beq_redirect_drop", redirect, 0);

        // BGEZAL not taken on a negative operand, link still written
        issue(enc_i(1, 17, 8), 32'h200, 32'hFFFF_FFFF, 0);
        check("bgezal_cond", cond_true, 0);
        check("bgezal_link_en", link_en, 1);
        check("bgezal_link_reg", link_reg, 31);
        check("bgezal_link_addr", link_addr, 32'h208);
        issue(nop, 32'h204, 0, 0);
        check("bgezal_no_redirect", redirect, 0);

        // JALR with a branch in its delay slot
        issue({6'd0, 5'd2, 5'd0, 5'd7, 5'd0, 6'h09}, 32'h300, 32'h4000, 0);
        check("jalr_link_reg", link_reg, 7);
        issue(enc_i(5, 3, 1), 32'h304, 1, 2);
        check("ds_err", ds_err, 1);
        check("ds_is_branch", is_branch, 0);
        check("jalr_target", redirect_pc, 32'h4000);

        // taken BNE, stall holds, reset in the delay slot drops the redirect
        issue(enc_i(5, 3, 2), 32'h400, 1, 2);
        stall = 1'b1; in_valid = 1'b1; instruction = nop;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_valid", res_valid, 1);
            check("stall_hold_branch", is_branch, 1);
        end
        stall = 1'b0; in_valid = 1'b0; reset = 1'b1;
        step();
        check("rst_ds_cond", cond_true, 0);
        check("rst_ds_redirect_pc", redirect_pc, 0);
        reset = 1'b0;
        issue(nop, 32'h404, 0, 0);
        check("rst_no_redirect", redirect, 0);

        // counter saturation over five taken jump pairs
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue({6'd2, 26'h40 + 26'(i)}, 32'h1000 + 32'(i * 8), 0, 0);
            issue(nop, 32'h1004 + 32'(i * 8), 0, 0);
        end
        check("sat_branch_cnt", branch_cnt, STATS ? 3 : 0);
        check("sat_taken_cnt", taken_cnt, STATS ? 3 : 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            in_valid = (r[3:0] < 4'd11);
            stall = (r[7:4] < 4'd2);
            flush = (r[11:8] == 4'd0);
            reset = (r[19:12] < 8'd4);
            instruction = rand_instr();
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            rs_val = $urandom;
            case (r[23:21])
                3'd0: rs_val = '0;
                3'd1: rs_val = {DATA_W{1'b1}};
                default: ;
            endcase
            rt_val = r[24] ? rs_val : DATA_W'($urandom);
            step();
        end
        {in_valid, stall, flush, reset} = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_condition_unit.md
BRANCH_CONDITION_UNIT -- requirements
Module: branch_condition_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand compare width, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid in 1, instruction in 32, pc in 32 (instruction address), rs_val in DATA_W, rt_val in DATA_W.
REQ-006 SHALL have ports stall in 1 (hold all state) and flush in 1 (discard pending control flow).
REQ-007 SHALL have outputs res_valid 1, is_branch 1, cond_true 1, link_en 1, link_reg 5, link_addr 32.
REQ-008 SHALL have outputs redirect 1, redirect_pc 32, ds_err 1, branch_cnt CNT_W, taken_cnt CNT_W.

Function
REQ-009 SHALL accept an instruction on a clock edge where in_valid=1, stall=0, flush=0, reset=0.
REQ-010 SHALL register all results: res_valid=1 for exactly the cycle after an accept, 0 otherwise (1-cycle latency).
REQ-011 SHALL decode is_branch for BEQ, BNE, BLEZ, BGTZ, REGIMM (rt = 00000, 00001, 10000, 10001), J, JAL, and opcode 0 with funct JR/JALR; every other encoding yields is_branch=0, cond_true=0.
REQ-012 SHALL compute cond_true from operands, signed over DATA_W bits: BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0; BLTZ/BLTZAL rs<0; BGEZ/BGEZAL rs>=0; J/JAL/JR/JALR always 1.
REQ-013 SHALL set link_en=1 for JAL, JALR, BLTZAL and BGEZAL regardless of cond_true; link_reg=31, except JALR uses instruction[15:11]; link_addr=pc+8 (mod 2^32).
REQ-014 SHALL form the target as: conditional branches pc+4+(sign-extended imm16<<2); J/JAL {pc+4[31:28], instr[25:0], 00}; JR/JALR rs_val zero-extended or truncated to 32 bits.
REQ-015 SHALL implement FSM states NORMAL and DELAY_SLOT; NORMAL->DELAY_SLOT on accepting any is_branch instruction; the target and cond_true are latched as pending.
REQ-016 SHALL, in DELAY_SLOT on the next accept, register redirect=1 and redirect_pc=pending target for one cycle if pending cond_true=1, then return to NORMAL; not-taken returns to NORMAL with redirect=0.
REQ-017 SHALL treat a branch accepted in DELAY_SLOT as a non-branch (is_branch=0, link_en=0, not counted) and pulse ds_err=1 alongside its res_valid.
REQ-018 SHALL, while stall=1 with flush=0, hold FSM, pending target and all outputs at their previous values.
REQ-019 SHALL give priority reset > flush > stall; flush forces NORMAL, clears pending, and zeroes res_valid, redirect and ds_err the next cycle.
REQ-020 SHALL keep redirect_pc and link_addr at their last values when the corresponding strobe is 0.

Reset
REQ-021 SHALL, on reset, clear every output to 0, set FSM=NORMAL, clear the pending target and cond_true, and zero both counters.
REQ-022 SHALL, on reset asserted while in DELAY_SLOT, drop the pending redirect; no redirect follows reset release.

Configuration
REQ-023 SHALL, with macro BRANCH_STATS_EN defined, increment branch_cnt on every accepted is_branch and taken_cnt on every redirect pulse, both saturating at 2^CNT_W-1.
REQ-024 SHALL, without BRANCH_STATS_EN, tie branch_cnt and taken_cnt to 0 and instantiate no counter logic.

Verification
REQ-025 SHALL cover BEQ at pc=0x100, imm=4, rs=rt=5, then a NOP -> res_valid/cond_true=1, then redirect=1, redirect_pc=0x114 one cycle after the NOP accept.
REQ-026 SHALL cover BGEZAL with rs=0xFFFFFFFF -> cond_true=0, link_en=1, link_reg=31, link_addr=pc+8; delay-slot accept -> redirect=0.
REQ-027 SHALL cover JALR rd=7, rs=0x4000, followed by BNE in the delay slot -> ds_err=1, is_branch=0, then redirect_pc=0x4000.
REQ-028 SHALL cover a taken BNE, then stall=1 for 3 cycles, then reset=1 during DELAY_SLOT -> outputs held while stalled, then all 0, and no redirect after release.
REQ-029 SHALL cover, with BRANCH_STATS_EN and CNT_W=2, 5 taken J+NOP pairs -> branch_cnt=taken_cnt=3 (saturated).
